// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: scheduler, RMW ALU and memory-port signals of the LSU front end
interface lsu_mem_arbiter_if;
  logic [15:0] agu_addr;
  logic        sched_load;
  logic        sched_store;
  logic [15:0] sched_data;
  logic        sched_ack;
  logic        lsu_deny_op;
  logic        lsu_data_rdy;
  logic [15:0] lsu_data;
  logic [15:0] lsu_addr;
  logic        lsu_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rdy;
  logic        load_done;
  modport master (
    output agu_addr, sched_load, sched_store, sched_data, lsu_deny_op,
           lsu_data_rdy, lsu_data, lsu_addr, mem_rdy,
    input  sched_ack, lsu_ack, mem_req, mem_we, mem_addr, mem_wdata, load_done
  );
  modport slave (
    input  agu_addr, sched_load, sched_store, sched_data, lsu_deny_op,
           lsu_data_rdy, lsu_data, lsu_addr, mem_rdy,
    output sched_ack, lsu_ack, mem_req, mem_we, mem_addr, mem_wdata, load_done
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: store queue plus single-outstanding memory arbiter for loads, stores and RMW writes
module lsu_mem_arbiter #(
  parameter int STQ_DEPTH = 4,
  parameter int STQ_AW    = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  lsu_mem_arbiter_if.slave  bus,
  output logic [STQ_AW:0]   stq_count,
  output logic              stq_full
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, RMW_WR} state_t;
  state_t state, state_n;
  logic [15:0] stq_addr [STQ_DEPTH];
  logic [15:0] stq_data [STQ_DEPTH];
  logic [STQ_AW-1:0] head, tail, off;
  logic hazard, load_ok, store_ok, done, pop;
  assign stq_full      = stq_count == (STQ_AW+1)'(STQ_DEPTH);
  assign load_ok       = bus.sched_load && state == IDLE && !bus.lsu_data_rdy && !bus.lsu_deny_op && !hazard;
  assign store_ok      = bus.sched_store && !bus.sched_load && !stq_full && !bus.lsu_deny_op;
  assign bus.sched_ack = load_ok || store_ok;
  assign bus.lsu_ack   = state == IDLE && bus.lsu_data_rdy;
  assign done          = bus.mem_rdy && state != IDLE;
  assign pop           = done && state == STORE;
  assign bus.load_done = bus.mem_rdy && state == LOAD;
  // An entry is valid when its distance from head is below the count, head included.
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      off    = STQ_AW'(i) - head;
      hazard = hazard | (({1'b0, off} < stq_count) && stq_addr[i] == bus.agu_addr);
    end
  end
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = bus.lsu_data_rdy ? RMW_WR : load_ok ? LOAD : stq_count != '0 ? STORE : IDLE;
    else if (bus.mem_rdy)
      state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      stq_count     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= state_n != LOAD;
        bus.mem_addr  <= bus.lsu_data_rdy ? bus.lsu_addr : load_ok ? bus.agu_addr : stq_addr[head];
        bus.mem_wdata <= bus.lsu_data_rdy ? bus.lsu_data : stq_data[head];
      end else if (done) begin
        bus.mem_req <= 1'b0;
      end
      if (store_ok) begin
        stq_addr[tail] <= bus.agu_addr;
        stq_data[tail] <= bus.sched_data;
        tail           <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      stq_count <= stq_count + (STQ_AW+1)'(store_ok) - (STQ_AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed vectors with hand-computed expectations for lsu_mem_arbiter
module tb_lsu_mem_arbiter;
  logic clk = 1'b0;
  logic a_rst = 1'b1;
  logic [2:0] stq_count;
  logic stq_full;
  int total = 0;
  int bad = 0;
  lsu_mem_arbiter_if bus ();
  lsu_mem_arbiter #(.STQ_DEPTH(4), .STQ_AW(2)) dut (
    .clk(clk), .a_rst(a_rst), .bus(bus), .stq_count(stq_count), .stq_full(stq_full)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic half();
    @(negedge clk);
  endtask
  initial begin
    bus.agu_addr = 0; bus.sched_load = 0; bus.sched_store = 0; bus.sched_data = 0;
    bus.lsu_deny_op = 0; bus.lsu_data_rdy = 0; bus.lsu_data = 0; bus.lsu_addr = 0; bus.mem_rdy = 0;
    next(); next();
    a_rst = 0;
    half();
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    check("rst_sack", 32'(bus.sched_ack), 0);
    check("rst_lack", 32'(bus.lsu_ack), 0);
    check("rst_cnt", 32'(stq_count), 0);
    next();
    bus.mem_rdy = 1;
    half();
    check("idle_rdy_ld", 32'(bus.load_done), 0);
    next();
    bus.mem_rdy = 0;
    half();
    check("idle_rdy_req", 32'(bus.mem_req), 0);
    next();
    bus.sched_load = 1; bus.agu_addr = 16'h1234;
    half();
    check("ld_ack", 32'(bus.sched_ack), 1);
    next();
    bus.sched_load = 0;
    half();
    check("ld_ack_drop", 32'(bus.sched_ack), 0);
    check("ld_req", 32'(bus.mem_req), 1);
    check("ld_we", 32'(bus.mem_we), 0);
    check("ld_addr", 32'(bus.mem_addr), 32'h1234);
    next();
    half();
    check("ld_hold", 32'(bus.mem_req), 1);
    next();
    bus.mem_rdy = 1;
    half();
    check("ld_done", 32'(bus.load_done), 1);
    next();
    bus.mem_rdy = 0;
    half();
    check("ld_req_drop", 32'(bus.mem_req), 0);
    check("ld_done_drop", 32'(bus.load_done), 0);
    next();
    bus.sched_load = 1; bus.agu_addr = 16'h3000;
    half();
    check("fill_ld_ack", 32'(bus.sched_ack), 1);
    next();
    bus.sched_load = 0;
    for (int k = 0; k < 4; k++) begin
      bus.sched_store = 1; bus.agu_addr = 16'h0010 + 16'(k); bus.sched_data = 16'h00A0 + 16'(k);
      half();
      check("fill_st_ack", 32'(bus.sched_ack), 1);
      next();
    end
    bus.agu_addr = 16'h0014; bus.sched_data = 16'h00A4;
    half();
    check("fill_cnt", 32'(stq_count), 4);
    check("fill_full", 32'(stq_full), 1);
    check("fill_5th_ack", 32'(bus.sched_ack), 0);
    next();
    bus.sched_store = 0;
    bus.mem_rdy = 1;
    half();
    check("fill_ld_done", 32'(bus.load_done), 1);
    next();
    bus.mem_rdy = 0;
    next();
    for (int k = 0; k < 4; k++) begin
      half();
      check("drain_req", 32'(bus.mem_req), 1);
      check("drain_we", 32'(bus.mem_we), 1);
      check("drain_addr", 32'(bus.mem_addr), 32'h0010 + k);
      check("drain_data", 32'(bus.mem_wdata), 32'h00A0 + k);
      check("drain_cnt", 32'(stq_count), 4 - k);
      bus.mem_rdy = 1;
      next();
      bus.mem_rdy = 0;
      half();
      check("drain_cnt_after", 32'(stq_count), 3 - k);
      check("drain_req_drop", 32'(bus.mem_req), 0);
      next();
    end
    bus.sched_store = 1; bus.agu_addr = 16'h0040; bus.sched_data = 16'h0055;
    half();
    check("haz_st_ack", 32'(bus.sched_ack), 1);
    next();
    bus.sched_store = 0; bus.sched_load = 1;
    half();
    check("haz_ld_stall_idle", 32'(bus.sched_ack), 0);
    next();
    half();
    check("haz_ld_stall_st", 32'(bus.sched_ack), 0);
    check("haz_st_addr", 32'(bus.mem_addr), 32'h0040);
    check("haz_st_we", 32'(bus.mem_we), 1);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    half();
    check("haz_ld_go", 32'(bus.sched_ack), 1);
    check("haz_cnt", 32'(stq_count), 0);
    next();
    bus.sched_load = 0;
    half();
    check("haz_ld_addr", 32'(bus.mem_addr), 32'h0040);
    check("haz_ld_we", 32'(bus.mem_we), 0);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    next();
    bus.sched_store = 1; bus.agu_addr = 16'h0040; bus.sched_data = 16'h0066;
    half();
    check("nohaz_st_ack", 32'(bus.sched_ack), 1);
    next();
    bus.sched_store = 0; bus.sched_load = 1; bus.agu_addr = 16'h0041;
    half();
    check("nohaz_ld_ack", 32'(bus.sched_ack), 1);
    next();
    bus.sched_load = 0;
    half();
    check("nohaz_ld_addr", 32'(bus.mem_addr), 32'h0041);
    check("nohaz_cnt", 32'(stq_count), 1);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    next();
    half();
    check("nohaz_st_addr", 32'(bus.mem_addr), 32'h0040);
    check("nohaz_st_data", 32'(bus.mem_wdata), 32'h0066);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    next();
    bus.lsu_deny_op = 1; bus.sched_load = 1; bus.agu_addr = 16'h0900;
    half();
    check("deny_ld", 32'(bus.sched_ack), 0);
    next();
    bus.sched_load = 0; bus.sched_store = 1;
    half();
    check("deny_st", 32'(bus.sched_ack), 0);
    next();
    bus.sched_store = 0; bus.lsu_deny_op = 0;
    half();
    check("deny_cnt", 32'(stq_count), 0);
    check("deny_req", 32'(bus.mem_req), 0);
    next();
    bus.sched_load = 1; bus.agu_addr = 16'h0500;
    half();
    check("rmw_pre_ld", 32'(bus.sched_ack), 1);
    next();
    bus.sched_load = 0; bus.sched_store = 1; bus.agu_addr = 16'h0077; bus.sched_data = 16'h1111;
    half();
    check("rmw_pre_st", 32'(bus.sched_ack), 1);
    next();
    bus.sched_store = 0; bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    bus.lsu_data_rdy = 1; bus.lsu_addr = 16'h0200; bus.lsu_data = 16'hBEEF;
    bus.sched_load = 1; bus.agu_addr = 16'h0300;
    half();
    check("rmw_lack", 32'(bus.lsu_ack), 1);
    check("rmw_ld_blocked", 32'(bus.sched_ack), 0);
    next();
    bus.lsu_data_rdy = 0;
    half();
    check("rmw_lack_drop", 32'(bus.lsu_ack), 0);
    check("rmw_addr", 32'(bus.mem_addr), 32'h0200);
    check("rmw_data", 32'(bus.mem_wdata), 32'hBEEF);
    check("rmw_we", 32'(bus.mem_we), 1);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    half();
    check("rmw_then_ld", 32'(bus.sched_ack), 1);
    next();
    bus.sched_load = 0;
    half();
    check("rmw_ld_addr", 32'(bus.mem_addr), 32'h0300);
    check("rmw_ld_we", 32'(bus.mem_we), 0);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0;
    next();
    bus.sched_store = 1; bus.agu_addr = 16'h0088; bus.sched_data = 16'h2222;
    half();
    check("rmw_st_addr", 32'(bus.mem_addr), 32'h0077);
    check("rmw_st_data", 32'(bus.mem_wdata), 32'h1111);
    check("both_st_ack", 32'(bus.sched_ack), 1);
    bus.mem_rdy = 1;
    next();
    bus.mem_rdy = 0; bus.sched_store = 0;
    half();
    check("both_cnt", 32'(stq_count), 1);
    next();
    half();
    check("wrap_st_addr", 32'(bus.mem_addr), 32'h0088);
    check("wrap_st_req", 32'(bus.mem_req), 1);
    a_rst = 1;
    next();
    a_rst = 0;
    half();
    check("mid_rst_req", 32'(bus.mem_req), 0);
    check("mid_rst_cnt", 32'(stq_count), 0);
    next();
    half();
    check("mid_rst_idle", 32'(bus.mem_req), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
